// File: rtl/instr_prefetch_ctrl.sv
// Instruction-fetch sequencer: walks the fetch PC through a combinational ROM and
// buffers {pc, word} pairs in a small FIFO drained by decode over valid/ready.
module instr_prefetch_ctrl #(
  parameter int                ADDR_W    = 32,
  parameter int                INSTR_W   = 32,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'hBFC00000,
  parameter int                ROM_BYTES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  output logic [ADDR_W-1:0]  rom_a_o,
  input  logic [INSTR_W-1:0] rom_rd_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               misalign_o,
  output logic               oob_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ROM_LAST = RESET_PC + ADDR_W'(ROM_BYTES - 4);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OOB} state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_pc_mem   [DEPTH];
  logic [INSTR_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_misalign;

  logic w_valid, w_pop, w_push, w_redirect, w_oob;

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && instr_ready_i;
  assign w_redirect = redirect_i && (r_state != S_IDLE);
  assign w_oob      = (r_fetch_pc < RESET_PC) || (r_fetch_pc > ROM_LAST);
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push     = (r_state == S_RUN) && !w_redirect && !w_oob &&
                      ((r_count < CNT_W'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en_i) w_state_nxt = S_RUN;
      S_RUN:   if (w_redirect) w_state_nxt = S_RUN;
               else if (w_oob) w_state_nxt = S_OOB;
      S_OOB:   if (w_redirect) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_redirect && (redirect_pc_i[1:0] != 2'b00);
      if (w_redirect) begin
        // Flush wins over any same-cycle pop; low address bits are dropped.
        r_fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
          r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
      r_data_mem[r_wr_ptr] <= rom_rd_i;
    end
  end

  assign rom_a_o       = r_fetch_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_data_mem[r_rd_ptr] : '0;
  assign instr_pc_o    = w_valid ? r_pc_mem[r_rd_ptr]   : '0;
  assign misalign_o    = r_misalign;
  assign oob_o         = (r_state == S_OOB);
endmodule

// File: tb/tb_instr_prefetch_ctrl.sv
// Directed bench for instr_prefetch_ctrl: expected {pc, word} pairs are queued by
// the stimulus and a negedge monitor compares every accepted FIFO head against them.
module tb_instr_prefetch_ctrl;
  localparam logic [31:0] BASE = 32'hBFC00000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en_i, instr_ready_i, redirect_i;
  logic [31:0] rom_a_o, rom_rd_i, instr_o, instr_pc_o, redirect_pc_i;
  logic        instr_valid_o, misalign_o, oob_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] k;
    k = (a - BASE) >> 2;
    return 32'hC0DE0000 | {16'h0, k[15:0]};
  endfunction

  assign rom_rd_i = rom_word(rom_a_o);

  instr_prefetch_ctrl dut (
    .clk(clk), .rst(rst), .en_i(en_i),
    .rom_a_o(rom_a_o), .rom_rd_i(rom_rd_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .misalign_o(misalign_o), .oob_o(oob_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc   = start + 32'(4 * i);
      e.data = rom_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // Accepted handshake = valid && ready at the coming edge, unless a redirect discards it.
  always @(negedge clk) begin
    if (!rst && !redirect_i && instr_valid_o && instr_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_pc", instr_pc_o, 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_pc", instr_pc_o, e.pc);
        chk("pop_data", instr_o, e.data);
      end
    end
  end

  initial begin
    rst = 1'b1; en_i = 1'b0; instr_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;

    // Reset state
    step(); step();
    neg();
    chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", instr_pc_o, 32'd0);
    chk("rst_rom_a", rom_a_o, BASE);
    chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
    chk("rst_oob", {31'b0, oob_o}, 32'd0);

    // 1: sequential fetch, no gaps
    expect_seq(BASE, 8);
    step(); rst = 1'b0; en_i = 1'b1; instr_ready_i = 1'b1;
    neg(); chk("t1_idle_valid", {31'b0, instr_valid_o}, 32'd0);
    step();
    neg(); chk("t1_first_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("t1_first_rom_a", rom_a_o, BASE);
    for (int i = 0; i < 8; i++) begin
      step();
      neg(); chk("t1_stream_valid", {31'b0, instr_valid_o}, 32'd1);
    end
    step(); rst = 1'b1; instr_ready_i = 1'b0;
    neg(); chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // 2: backpressure to full, then push/pop together
    step(); rst = 1'b0; en_i = 1'b1;
    for (int i = 0; i < 9; i++) step();
    neg();
    chk("t2_full_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("t2_stall_rom_a", rom_a_o, BASE + 32'h10);
    chk("t2_head_pc", instr_pc_o, BASE);
    expect_seq(BASE, 8);
    step(); instr_ready_i = 1'b1;
    neg(); chk("t2_pp_rom_a0", rom_a_o, BASE + 32'h10);
    step();
    neg(); chk("t2_pp_rom_a1", rom_a_o, BASE + 32'h14);
    for (int i = 0; i < 6; i++) step();
    step(); rst = 1'b1; instr_ready_i = 1'b0;
    neg(); chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3: redirect flush with 3 words buffered and a same-cycle ready
    step(); rst = 1'b0; en_i = 1'b1;
    step(); step(); step();
    step(); redirect_i = 1'b1; redirect_pc_i = BASE + 32'h100; instr_ready_i = 1'b1;
    neg(); chk("t3_pre_count3_pc", instr_pc_o, BASE);
    chk("t3_pre_rom_a", rom_a_o, BASE + 32'hC);
    expect_seq(BASE + 32'h100, 3);
    step(); redirect_i = 1'b0;
    neg(); chk("t3_flush_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("t3_flush_rom_a", rom_a_o, BASE + 32'h100);
    chk("t3_no_misalign", {31'b0, misalign_o}, 32'd0);
    step();
    neg(); chk("t3_head_valid", {31'b0, instr_valid_o}, 32'd1);
    step(); step();

    // 4: misaligned redirect
    step(); redirect_i = 1'b1; redirect_pc_i = BASE + 32'h43;
    neg(); chk("t4_drained", 32'(exp_q.size()), 32'd0);
    expect_seq(BASE + 32'h40, 2);
    step(); redirect_i = 1'b0;
    neg(); chk("t4_misalign_hi", {31'b0, misalign_o}, 32'd1);
    chk("t4_rom_a", rom_a_o, BASE + 32'h40);
    step();
    neg(); chk("t4_misalign_lo", {31'b0, misalign_o}, 32'd0);
    step();

    // 5: run off the end of the ROM window
    step(); redirect_i = 1'b1; redirect_pc_i = BASE + 32'hFF8;
    neg(); chk("t5_pre_drained", 32'(exp_q.size()), 32'd0);
    expect_seq(BASE + 32'hFF8, 2);
    step(); redirect_i = 1'b0;
    step();
    step();
    neg(); chk("t5_last_oob", {31'b0, oob_o}, 32'd0);
    chk("t5_last_rom_a", rom_a_o, BASE + 32'h1000);
    step();
    neg(); chk("t5_oob_hi", {31'b0, oob_o}, 32'd1);
    chk("t5_oob_valid", {31'b0, instr_valid_o}, 32'd0);
    step();
    neg(); chk("t5_oob_hold", {31'b0, oob_o}, 32'd1);
    chk("t5_oob_rom_a", rom_a_o, BASE + 32'h1000);
    chk("t5_oob_drained", 32'(exp_q.size()), 32'd0);
    step(); redirect_i = 1'b1; redirect_pc_i = BASE;
    neg();
    expect_seq(BASE, 1);
    step(); redirect_i = 1'b0;
    neg(); chk("t5_oob_cleared", {31'b0, oob_o}, 32'd0);
    chk("t5_restart_rom_a", rom_a_o, BASE);
    step();

    // 6: reset with a full FIFO, then redirect ignored in IDLE
    step(); instr_ready_i = 1'b0;
    step(); step(); step();
    neg(); chk("t6_full_rom_a", rom_a_o, BASE + 32'h14);
    chk("t6_full_valid", {31'b0, instr_valid_o}, 32'd1);
    step(); rst = 1'b1; en_i = 1'b0;
    step(); rst = 1'b0;
    neg(); chk("t6_rst_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("t6_rst_rom_a", rom_a_o, BASE);
    step(); redirect_i = 1'b1; redirect_pc_i = BASE + 32'h100;
    neg(); chk("t6_idle_rom_a", rom_a_o, BASE);
    step(); redirect_i = 1'b0;
    neg(); chk("t6_idle_redirect_ignored", rom_a_o, BASE);
    chk("t6_idle_no_misalign", {31'b0, misalign_o}, 32'd0);
    chk("t6_idle_valid", {31'b0, instr_valid_o}, 32'd0);
    redirect_pc_i = BASE + 32'h43;
    step(); en_i = 1'b1;
    step();
    step();
    neg(); chk("t6_restart_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("t6_restart_pc", instr_pc_o, BASE);
    chk("t6_restart_data", instr_o, rom_word(BASE));
    chk("t6_final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
